clk_gate_ctrl: RTL and testbench
================================

// Module: clk_gate_ctrl
// PURPOSE
//  Enable-side controller for the clock_gating block. Watches downstream activity and
//  upstream wake requests, then drives the ICG enable. Gates the clock after a
//  programmable idle time and ungates it on demand through a req/ack wake handshake.
//  Runs on the free (ungated) clock; gate_en_o connects directly to clock_gating.en.
// PARAMETERS
//  CNT_W        8   width of the internal idle/wake counter
//  IDLE_CYCLES  8   consecutive idle cycles before gating (1..2**CNT_W-1)
//  WAKE_CYCLES  2   cycles with enable high before a wake is acknowledged (1..2**CNT_W-1)
// PORTS
//  clk          in   1  free-running clock
//  rstn         in   1  asynchronous active-low reset
//  busy_i       in   1  downstream logic active this cycle
//  req_i        in   1  wake/run request; level, held high until ack_o is seen
//  force_on_i   in   1  software override: keeps the clock running, no gating
//  gate_en_o    out  1  registered enable to the ICG (1 = clock runs)
//  ack_o        out  1  one-cycle pulse: gated clock is guaranteed running for req_i
//  gated_o      out  1  registered status: 1 while in GATED
// BEHAVIOUR
//  Reset: one clock; rstn is asynchronous and active-low. While rstn=0, state=RUN,
//   gate_en_o=1 (downstream flops see clock during reset), ack_o=0, gated_o=0,
//   cnt=0, ack_done=0. A reset mid-operation, including in GATED, takes effect
//   immediately: no ack is issued and any pending req must be re-served.
//  "wake" = busy_i | req_i | force_on_i. All outputs are registered from state.
//  FSM:
//   RUN   : gate_en=1. If !wake, go to COUNT with cnt=0.
//   COUNT : gate_en=1. If wake, go to RUN with cnt=0.
//           Else if cnt==IDLE_CYCLES-1, go to GATED. Else cnt++.
//   GATED : gate_en=0, gated=1. If wake, go to WAKE with cnt=0.
//   WAKE  : gate_en=1. At cnt==WAKE_CYCLES-1, go to RUN; else cnt++. wake is ignored here.
//  Gating latency: busy_i falls at edge N, so gate_en_o=0 after edge N+1+IDLE_CYCLES.
//  ack rules: a flag ack_done is set with ack_o and cleared when req_i=0.
//   ack_o=1 for one cycle when req_i & !ack_done & next state is RUN or COUNT
//   (from RUN/COUNT: 1 cycle after req_i rises; from GATED: 1+WAKE_CYCLES cycles).
//   Exactly one ack per req_i high period; req_i dropping before ack aborts silently.
//  Simultaneous events: on the IDLE_CYCLES-1 boundary, wake wins (go to RUN, no gate).
//   In WAKE, a req_i that rises mid-wake is acked with the same WAKE exit.
//  Counter never wraps; parameter bounds are checked at elaboration ($error).
//  gate_en_o only changes on clk rising edges, so it is stable for the ICG latch phase.
// CONFIGURATION
//  `CLK_GATE_CTRL_STATS_EN defined: adds ports stats_clr_i (in, 1) and
//   gated_cycles_o (out, 32). gated_cycles_o counts cycles with gated_o=1 and
//   saturates at 32'hFFFF_FFFF. It is synchronously cleared by stats_clr_i (clear
//   wins over increment) and is 0 at reset.
//  Undefined: those ports and the counter do not exist; all other behaviour is identical.
// STRUCTURE
//  clk_gate_ctrl_pkg: state enum (RUN, COUNT, GATED, WAKE; 2-bit, RUN=2'b00) and
//   STATS_W=32 constant.
//  One sub-module, cg_sat_counter (parameter W, inputs inc/clr, output q), used only
//   under `CLK_GATE_CTRL_STATS_EN. The FSM and idle counter stay in clk_gate_ctrl.
// TESTING (IDLE_CYCLES=4, WAKE_CYCLES=2, 10 ns clk)
//  1 Reset release, busy_i=0 throughout -> gate_en_o=1 through COUNT; 0 at the 5th
//    edge after reset release; gated_o=1 on the same edge.
//  2 busy_i pulses 1 cycle during every 3rd COUNT cycle -> gate_en_o never drops;
//    busy_i on cnt=3 keeps the clock on (boundary wake-wins).
//  3 From GATED, req_i=1 held -> gate_en_o=1 next edge, ack_o pulses exactly once
//    3 edges after req_i rises; no 2nd ack while req_i stays high.
//  4 req_i in RUN -> ack_o 1 edge later. Drop req_i, re-raise it -> second single ack.
//  5 Assert rstn=0 mid-WAKE (asynchronously) -> gate_en_o=1, ack_o=0, gated_o=0
//    immediately; no ack after release until req_i is re-served.
//  6 STATS_EN: gate for 20 cycles -> gated_cycles_o=20. stats_clr_i together with
//    gated -> 0; force_on_i=1 -> no gating at all.

Source files
------------

// File: rtl/clk_gate_ctrl_pkg.sv
// rtl/clk_gate_ctrl_pkg.sv - shared types and constants for the clock gate enable controller
package clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_COUNT = 2'b01,
    ST_GATED = 2'b10,
    ST_WAKE  = 2'b11
  } cg_state_e;

  localparam int STATS_W = 32;

endpackage

// File: rtl/cg_sat_counter.sv
// rtl/cg_sat_counter.sv - saturating event counter with synchronous clear
// Clear takes priority over increment; the count holds at all-ones.
module cg_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - ICG enable controller: idle-timeout gating and req/ack wake
// Optional gated-cycle statistics are built when CLK_GATE_CTRL_STATS_EN is defined.
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               busy_i,
  input  logic               req_i,
  input  logic               force_on_i,
  output logic               gate_en_o,
  output logic               ack_o,
  output logic               gated_o
`ifdef CLK_GATE_CTRL_STATS_EN
  ,
  input  logic               stats_clr_i,
  output logic [STATS_W-1:0] gated_cycles_o
`endif
);

  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_COUNT = ST_COUNT;
  localparam logic [1:0] S_GATED = ST_GATED;
  localparam logic [1:0] S_WAKE  = ST_WAKE;

  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

  if (IDLE_CYCLES < 1 || IDLE_CYCLES > CNT_MAX) begin : g_bad_idle
    $error("clk_gate_ctrl: IDLE_CYCLES out of range for CNT_W");
  end
  if (WAKE_CYCLES < 1 || WAKE_CYCLES > CNT_MAX) begin : g_bad_wake
    $error("clk_gate_ctrl: WAKE_CYCLES out of range for CNT_W");
  end

  logic [1:0]       state, nstate;
  logic [CNT_W-1:0] cnt, ncnt;
  logic             ack_done;
  logic             wake;
  logic             ack_next;

  assign wake = busy_i | req_i | force_on_i;

  // Counter reloads on every transition that needs it, so it can never wrap.
  always_comb begin
    nstate = state;
    ncnt   = cnt;
    case (state)
      S_RUN: begin
        if (!wake) begin
          nstate = S_COUNT;
          ncnt   = '0;
        end
      end
      S_COUNT: begin
        if (wake) begin
          nstate = S_RUN;
          ncnt   = '0;
        end else if (cnt == IDLE_LAST) begin
          nstate = S_GATED;
        end else begin
          ncnt = cnt + 1'b1;
        end
      end
      S_GATED: begin
        if (wake) begin
          nstate = S_WAKE;
          ncnt   = '0;
        end
      end
      S_WAKE: begin
        if (cnt == WAKE_LAST) begin
          nstate = S_RUN;
        end else begin
          ncnt = cnt + 1'b1;
        end
      end
      default: begin
        nstate = S_RUN;
        ncnt   = '0;
      end
    endcase
  end

  // Ack only once the clock is known to be running: the next state is RUN or COUNT.
  assign ack_next = req_i && !ack_done && ((nstate == S_RUN) || (nstate == S_COUNT));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_RUN;
      cnt       <= '0;
      ack_done  <= 1'b0;
      gate_en_o <= 1'b1;
      ack_o     <= 1'b0;
      gated_o   <= 1'b0;
    end else begin
      state     <= nstate;
      cnt       <= ncnt;
      gate_en_o <= (nstate != S_GATED);
      gated_o   <= (nstate == S_GATED);
      ack_o     <= ack_next;
      if (ack_next) begin
        ack_done <= 1'b1;
      end else if (!req_i) begin
        ack_done <= 1'b0;
      end
    end
  end

`ifdef CLK_GATE_CTRL_STATS_EN
  cg_sat_counter #(
    .W (STATS_W)
  ) u_gated_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (gated_o),
    .clr  (stats_clr_i),
    .q    (gated_cycles_o)
  );
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb/tb_clk_gate_ctrl.sv - directed self-checking bench for clk_gate_ctrl
module tb_clk_gate_ctrl;

  logic clk = 1'b0;
  logic rstn;
  logic busy_i, req_i, force_on_i;
  logic gate_en_o, ack_o, gated_o;
`ifdef CLK_GATE_CTRL_STATS_EN
  logic        stats_clr_i;
  logic [31:0] gated_cycles_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clk_gate_ctrl #(
    .CNT_W       (8),
    .IDLE_CYCLES (4),
    .WAKE_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .busy_i     (busy_i),
    .req_i      (req_i),
    .force_on_i (force_on_i),
    .gate_en_o  (gate_en_o),
    .ack_o      (ack_o),
    .gated_o    (gated_o)
`ifdef CLK_GATE_CTRL_STATS_EN
    ,
    .stats_clr_i    (stats_clr_i),
    .gated_cycles_o (gated_cycles_o)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic en, input logic ack, input logic gtd);
    chk({tag, ".gate_en"}, {31'd0, gate_en_o}, {31'd0, en});
    chk({tag, ".ack"},     {31'd0, ack_o},     {31'd0, ack});
    chk({tag, ".gated"},   {31'd0, gated_o},   {31'd0, gtd});
  endtask

  initial begin
    rstn = 1'b0; busy_i = 1'b0; req_i = 1'b0; force_on_i = 1'b0;
`ifdef CLK_GATE_CTRL_STATS_EN
    stats_clr_i = 1'b0;
`endif
    step(); step();
    chk_out("reset", 1'b1, 1'b0, 1'b0);
    rstn = 1'b1;

    // 1: idle from reset, gates on the 5th edge
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_out("idle_count", 1'b1, 1'b0, 1'b0);
    end
    step();
    chk_out("gate_edge5", 1'b0, 1'b0, 1'b1);

    // 3: wake from GATED, ack 3 edges after req rises, once only
    req_i = 1'b1;
    step(); chk_out("wake_e1", 1'b1, 1'b0, 1'b0);
    step(); chk_out("wake_e2", 1'b1, 1'b0, 1'b0);
    step(); chk_out("wake_ack", 1'b1, 1'b1, 1'b0);
    step(); chk_out("no_2nd_ack_a", 1'b1, 1'b0, 1'b0);
    step(); chk_out("no_2nd_ack_b", 1'b1, 1'b0, 1'b0);

    // 4: req in RUN acked one edge later; re-raise gives a second ack
    req_i = 1'b0; busy_i = 1'b1;
    step(); chk_out("run_idle", 1'b1, 1'b0, 1'b0);
    req_i = 1'b1;
    step(); chk_out("run_ack1", 1'b1, 1'b1, 1'b0);
    step(); chk_out("run_hold", 1'b1, 1'b0, 1'b0);
    req_i = 1'b0;
    step(); chk_out("run_drop", 1'b1, 1'b0, 1'b0);
    req_i = 1'b1;
    step(); chk_out("run_ack2", 1'b1, 1'b1, 1'b0);
    step(); chk_out("run_hold2", 1'b1, 1'b0, 1'b0);
    req_i = 1'b0;

    // 2: busy pulses during COUNT keep the clock on, incl. the last-count boundary
    for (int r = 0; r < 3; r++) begin
      busy_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
        step(); chk_out("pulse_count", 1'b1, 1'b0, 1'b0);
      end
      busy_i = 1'b1;
      step(); chk_out("pulse_busy", 1'b1, 1'b0, 1'b0);
    end
    busy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); chk_out("bnd_count", 1'b1, 1'b0, 1'b0);
    end
    busy_i = 1'b1;
    step(); chk_out("bnd_wake_wins", 1'b1, 1'b0, 1'b0);
    busy_i = 1'b0;

    // 5: async reset mid-WAKE and in GATED
    for (int i = 0; i < 5; i++) step();
    chk_out("regate", 1'b0, 1'b0, 1'b1);
    req_i = 1'b1;
    step(); chk_out("wake_before_rst", 1'b1, 1'b0, 1'b0);
    #2 rstn = 1'b0;
    #1 chk_out("rst_mid_wake", 1'b1, 1'b0, 1'b0);
    step(); chk_out("rst_held", 1'b1, 1'b0, 1'b0);
    rstn = 1'b1;
    step(); chk_out("reserve_ack", 1'b1, 1'b1, 1'b0);
    req_i = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk_out("gated_pre_rst", 1'b0, 1'b0, 1'b1);
    #2 rstn = 1'b0;
    #1 chk_out("rst_in_gated", 1'b1, 1'b0, 1'b0);
    step();
    rstn = 1'b1;

    // 6: force_on prevents gating
    force_on_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(); chk_out("force_on", 1'b1, 1'b0, 1'b0);
    end
    force_on_i = 1'b0;

`ifdef CLK_GATE_CTRL_STATS_EN
    stats_clr_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk_out("stats_gate", 1'b0, 1'b0, 1'b1);
    chk("stats_cleared", gated_cycles_o, 32'd0);
    stats_clr_i = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("stats_20", gated_cycles_o, 32'd20);
    stats_clr_i = 1'b1;
    step();
    chk("stats_clr_wins", gated_cycles_o, 32'd0);
    stats_clr_i = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
